// File: rtl/ntt_reorder_buffer_if.sv
// Stream interface of the NTT reorder buffer: a coefficient input side and a
// natural-order output side, each with its own valid/ready pair.
interface ntt_reorder_buffer_if #(
  parameter int width = 16
);
  // A beat transfers on a rising clk edge where valid && ready are both high.
  // Once valid is raised, the sender holds valid and its payload (data, select,
  // last) stable until that transfer. ready may change freely.
  logic             in_valid;
  logic             in_ready;
  logic [width-1:0] in_data;
  logic             select;
  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] out_data;
  logic             out_last;

  modport master (
    output in_valid, in_data, select, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, select, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/ntt_reorder_buffer.sv
// Ping-pong frame buffer that turns bit-reversed NTT output frames into
// natural order. INTT frames, which are already natural, are only buffered.
module ntt_reorder_buffer #(
  parameter int width = 16,
  parameter int log_n = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  ntt_reorder_buffer_if.slave bus
);
  localparam int n = 1 << log_n;
  localparam logic [log_n-1:0] last_idx = {log_n{1'b1}};

  logic [width-1:0] mem [2][n];

  logic             wr_bank;
  logic             rd_bank;
  logic [log_n-1:0] wr_cnt;
  logic [log_n-1:0] rd_cnt;
  logic [1:0]       full;
  logic [1:0]       mode;

  logic             wr_fire;
  logic             rd_fire;
  logic             wr_mode;
  logic [log_n-1:0] wr_addr;

  function automatic logic [log_n-1:0] bitrev(input logic [log_n-1:0] a);
    logic [log_n-1:0] r;
    for (int i = 0; i < log_n; i++) r[i] = a[log_n-1-i];
    return r;
  endfunction

  assign bus.in_ready  = !full[wr_bank];
  assign bus.out_valid = full[rd_bank];
  assign bus.out_data  = mem[rd_bank][rd_cnt];
  assign bus.out_last  = full[rd_bank] && (rd_cnt == last_idx);

  assign wr_fire = bus.in_valid && !full[wr_bank];
  assign rd_fire = full[rd_bank] && bus.out_ready;

  // The first coefficient of a frame uses select directly, since the mode bit
  // for this bank is only being latched on that same edge.
  assign wr_mode = (wr_cnt == '0) ? bus.select : mode[wr_bank];
  assign wr_addr = wr_mode ? wr_cnt : bitrev(wr_cnt);

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_bank][wr_addr] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      full    <= '0;
      mode    <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_cnt == '0) mode[wr_bank] <= bus.select;
        if (wr_cnt == last_idx) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          wr_cnt        <= '0;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
      // A filling bank is never full and a draining bank always is, so the
      // set above and the clear below can never hit the same flag.
      if (rd_fire) begin
        if (rd_cnt == last_idx) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
          rd_cnt        <= '0;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ntt_reorder_buffer.sv
// Bench for ntt_reorder_buffer at N = 8: directed frame scenarios plus a
// randomized stall run checked against a permutation model of each frame.
module tb_ntt_reorder_buffer;
  localparam int width = 16;
  localparam int log_n = 3;
  localparam int n     = 8;

  typedef logic [width-1:0] frame_t [n];

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ntt_reorder_buffer_if #(.width(width)) bus ();

  ntt_reorder_buffer #(.width(width), .log_n(log_n)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int assert_cnt = 0;
  int fail_cnt   = 0;
  logic [width-1:0] exp_q[$];

  // Natural-order output position k carries the k-th accepted coefficient for
  // INTT frames and the bit-reversed-index coefficient for NTT frames.
  function automatic int model_src(input int k, input bit sel);
    int r;
    int v;
    r = 0;
    v = k;
    if (sel) return k;
    for (int b = 0; b < log_n; b++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  function automatic void model_frame(input frame_t d, input bit sel);
    for (int k = 0; k < n; k++) exp_q.push_back(d[model_src(k, sel)]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pushes one frame; select flips to ~sel from coefficient toggle_at onward.
  task automatic send_frame(input frame_t d, input bit sel, input int toggle_at);
    for (int i = 0; i < n; i++) begin
      int waited;
      waited       = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d[i];
      bus.select   = (toggle_at > 0 && i >= toggle_at) ? ~sel : sel;
      while (!bus.in_ready && waited < 500) begin
        step();
        waited++;
      end
      if (!bus.in_ready) begin
        assert_cnt++;
        fail_cnt++;
        $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", bus.in_ready, waited);
      end
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    assert_cnt++;
    if (bus.in_ready !== 1'b1) begin fail_cnt++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
    assert_cnt++;
    if (bus.out_valid !== 1'b0) begin fail_cnt++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
    assert_cnt++;
    if (bus.out_last !== 1'b0) begin fail_cnt++; $display("FAIL reset_out_last: got %0b want 0", bus.out_last); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_ntt_reorder();
    bus.out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = width'(i);
      bus.select   = 1'b0;
      assert_cnt++;
      if (bus.in_ready !== 1'b1) begin fail_cnt++; $display("FAIL ntt_in_ready[%0d]: got %0b want 1", i, bus.in_ready); end
      assert_cnt++;
      if (bus.out_valid !== 1'b0) begin fail_cnt++; $display("FAIL ntt_early_valid[%0d]: got %0b want 0", i, bus.out_valid); end
      step();
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      assert_cnt++;
      if (bus.out_valid !== 1'b1) begin fail_cnt++; $display("FAIL ntt_valid[%0d]: got %0b want 1", k, bus.out_valid); end
      assert_cnt++;
      if (bus.out_data !== width'(model_src(k, 1'b0))) begin
        fail_cnt++; $display("FAIL ntt_data[%0d]: got %0d want %0d", k, bus.out_data, model_src(k, 1'b0));
      end
      assert_cnt++;
      if (bus.out_last !== (k == n - 1)) begin fail_cnt++; $display("FAIL ntt_last[%0d]: got %0b want %0b", k, bus.out_last, k == n - 1); end
      step();
    end
    assert_cnt++;
    if (bus.out_valid !== 1'b0) begin fail_cnt++; $display("FAIL ntt_drained: out_valid got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_intt_pass();
    frame_t d;
    for (int i = 0; i < n; i++) d[i] = width'(10 + i);
    bus.out_ready = 1'b1;
    send_frame(d, 1'b1, 0);
    for (int k = 0; k < n; k++) begin
      assert_cnt++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== width'(10 + k)) begin
        fail_cnt++; $display("FAIL intt_data[%0d]: got v=%0b d=%0d want v=1 d=%0d", k, bus.out_valid, bus.out_data, 10 + k);
      end
      assert_cnt++;
      if (bus.out_last !== (k == n - 1)) begin fail_cnt++; $display("FAIL intt_last[%0d]: got %0b want %0b", k, bus.out_last, k == n - 1); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2 * n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = width'((i < n) ? 20 + i : 30 + i - n);
      bus.select   = (i >= n);
      assert_cnt++;
      if (bus.in_ready !== 1'b1) begin fail_cnt++; $display("FAIL bp_in_ready[%0d]: got %0b want 1", i, bus.in_ready); end
      step();
    end
    assert_cnt++;
    if (bus.in_ready !== 1'b0) begin fail_cnt++; $display("FAIL bp_both_full: in_ready got %0b want 0", bus.in_ready); end
    bus.in_data = 16'd99;
    step();
    bus.in_valid = 1'b0;
    assert_cnt++;
    if (bus.in_ready !== 1'b0) begin fail_cnt++; $display("FAIL bp_reject: in_ready got %0b want 0", bus.in_ready); end
    assert_cnt++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd20) begin
      fail_cnt++; $display("FAIL bp_hold: got v=%0b d=%0d want v=1 d=20", bus.out_valid, bus.out_data);
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      assert_cnt++;
      if (bus.out_data !== width'(20 + model_src(k, 1'b0))) begin
        fail_cnt++; $display("FAIL bp_frame1[%0d]: got %0d want %0d", k, bus.out_data, 20 + model_src(k, 1'b0));
      end
      if (k == n - 1) begin
        assert_cnt++;
        if (bus.in_ready !== 1'b0) begin fail_cnt++; $display("FAIL bp_ready_early: got %0b want 0", bus.in_ready); end
      end
      step();
    end
    assert_cnt++;
    if (bus.in_ready !== 1'b1) begin fail_cnt++; $display("FAIL bp_ready_return: got %0b want 1", bus.in_ready); end
    for (int k = 0; k < n; k++) begin
      assert_cnt++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== width'(30 + k) || bus.out_last !== (k == n - 1)) begin
        fail_cnt++; $display("FAIL bp_frame2[%0d]: got v=%0b d=%0d l=%0b want v=1 d=%0d l=%0b",
                             k, bus.out_valid, bus.out_data, bus.out_last, 30 + k, k == n - 1);
      end
      step();
    end
    assert_cnt++;
    if (bus.out_valid !== 1'b0) begin fail_cnt++; $display("FAIL bp_no_extra: out_valid got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_mode_per_frame();
    frame_t a;
    frame_t b;
    int got;
    int cyc;
    for (int i = 0; i < n; i++) begin
      a[i] = width'(i);
      b[i] = width'(8 + i);
    end
    exp_q.delete();
    model_frame(a, 1'b0);
    model_frame(b, 1'b1);
    bus.out_ready = 1'b1;
    got = 0;
    cyc = 0;
    fork
      begin
        send_frame(a, 1'b0, 3);
        send_frame(b, 1'b1, 4);
      end
      begin
        while (got < 2 * n && cyc < 400) begin
          if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
            logic [width-1:0] e;
            e = exp_q.pop_front();
            assert_cnt++;
            if (bus.out_data !== e || bus.out_last !== (got % n == n - 1)) begin
              fail_cnt++; $display("FAIL mode_out[%0d]: got d=%0d l=%0b want d=%0d l=%0b",
                                   got, bus.out_data, bus.out_last, e, got % n == n - 1);
            end
            got++;
          end
          step();
          cyc++;
        end
      end
    join
    assert_cnt++;
    if (got != 2 * n) begin fail_cnt++; $display("FAIL mode_count: got %0d outputs want %0d", got, 2 * n); end
  endtask

  task automatic test_random_stalls();
    localparam int frames = 20;
    frame_t fr [frames];
    bit     sel [frames];
    int got;
    int total;
    int cyc;
    exp_q.delete();
    for (int f = 0; f < frames; f++) begin
      sel[f] = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) fr[f][i] = width'($urandom_range(0, 65535));
      model_frame(fr[f], sel[f]);
    end
    total = exp_q.size();
    got   = 0;
    cyc   = 0;
    fork
      begin
        int budget;
        budget = 0;
        for (int f = 0; f < frames; f++) begin
          for (int i = 0; i < n; i++) begin
            bit done;
            done = 1'b0;
            while (!done && budget < 3000) begin
              bus.in_valid = ($urandom_range(0, 3) != 0);
              bus.in_data  = fr[f][i];
              bus.select   = (i == 0) ? sel[f] : 1'($urandom_range(0, 1));
              done = bus.in_valid && bus.in_ready;
              step();
              budget++;
            end
          end
        end
        bus.in_valid = 1'b0;
        if (budget >= 3000) begin
          assert_cnt++;
          fail_cnt++;
          $display("FAIL rand_drive_timeout: %0d cycles used, limit 3000", budget);
        end
      end
      begin
        bit               stalled;
        logic [width-1:0] held_data;
        logic             held_last;
        stalled = 1'b0;
        held_data = '0;
        held_last = 1'b0;
        while (got < total && cyc < 3000) begin
          bus.out_ready = ($urandom_range(0, 2) != 0);
          if (stalled) begin
            assert_cnt++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== held_data || bus.out_last !== held_last) begin
              fail_cnt++; $display("FAIL rand_stable: got v=%0b d=%0d l=%0b want v=1 d=%0d l=%0b",
                                   bus.out_valid, bus.out_data, bus.out_last, held_data, held_last);
            end
          end
          stalled   = bus.out_valid && !bus.out_ready;
          held_data = bus.out_data;
          held_last = bus.out_last;
          if (bus.out_valid && bus.out_ready) begin
            logic [width-1:0] e;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            assert_cnt++;
            if (bus.out_data !== e || bus.out_last !== (got % n == n - 1)) begin
              fail_cnt++; $display("FAIL rand_out[%0d]: got d=%0d l=%0b want d=%0d l=%0b",
                                   got, bus.out_data, bus.out_last, e, got % n == n - 1);
            end
            got++;
          end
          step();
          cyc++;
        end
      end
    join
    bus.out_ready = 1'b1;
    step();
    assert_cnt++;
    if (got != total) begin fail_cnt++; $display("FAIL rand_count: got %0d outputs want %0d", got, total); end
    assert_cnt++;
    if (bus.out_valid !== 1'b0) begin fail_cnt++; $display("FAIL rand_duplicate: out_valid got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    frame_t d;
    for (int i = 0; i < n; i++) d[i] = width'(40 + i);
    bus.out_ready = 1'b0;
    send_frame(d, 1'b0, 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = width'(50 + i);
      bus.select   = 1'b0;
      step();
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    assert_cnt++;
    if (bus.out_valid !== 1'b0) begin fail_cnt++; $display("FAIL rmid_out_valid: got %0b want 0", bus.out_valid); end
    assert_cnt++;
    if (bus.in_ready !== 1'b1) begin fail_cnt++; $display("FAIL rmid_in_ready: got %0b want 1", bus.in_ready); end
    step();
    assert_cnt++;
    if (bus.out_valid !== 1'b0) begin fail_cnt++; $display("FAIL rmid_still_empty: got %0b want 0", bus.out_valid); end
    for (int i = 0; i < n; i++) d[i] = width'(i);
    send_frame(d, 1'b0, 0);
    for (int k = 0; k < n; k++) begin
      assert_cnt++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== width'(model_src(k, 1'b0)) || bus.out_last !== (k == n - 1)) begin
        fail_cnt++; $display("FAIL rmid_frame[%0d]: got v=%0b d=%0d l=%0b want v=1 d=%0d l=%0b",
                             k, bus.out_valid, bus.out_data, bus.out_last, model_src(k, 1'b0), k == n - 1);
      end
      step();
    end
    assert_cnt++;
    if (bus.out_valid !== 1'b0) begin fail_cnt++; $display("FAIL rmid_drained: got %0b want 0", bus.out_valid); end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.select    = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_ntt_reorder();
    test_intt_pass();
    test_back_to_back();
    test_mode_per_frame();
    test_random_stalls();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end
endmodule
